// File: rtl/calc_pkg.sv
// Shared keypad types: raw button field vector and the decoded single-button code.
package calc_pkg;

    // Raw keypad levels, one bit per key; num_0 is bit 0, op_clr is bit 15.
    typedef struct packed {
        logic op_clr;
        logic op_eq;
        logic op_div;
        logic op_mul;
        logic op_sub;
        logic op_add;
        logic num_9;
        logic num_8;
        logic num_7;
        logic num_6;
        logic num_5;
        logic num_4;
        logic num_3;
        logic num_2;
        logic num_1;
        logic num_0;
    } buttons_t;

    // Decoded key: code is (bit index of the key in buttons_t) + 1, zero means none.
    typedef enum logic [4:0] {
        B_NONE   = 5'd0,
        B_NUM_0  = 5'd1,
        B_NUM_1  = 5'd2,
        B_NUM_2  = 5'd3,
        B_NUM_3  = 5'd4,
        B_NUM_4  = 5'd5,
        B_NUM_5  = 5'd6,
        B_NUM_6  = 5'd7,
        B_NUM_7  = 5'd8,
        B_NUM_8  = 5'd9,
        B_NUM_9  = 5'd10,
        B_OP_ADD = 5'd11,
        B_OP_SUB = 5'd12,
        B_OP_MUL = 5'd13,
        B_OP_DIV = 5'd14,
        B_OP_EQ  = 5'd15,
        B_OP_CLR = 5'd16
    } active_button_t;

endpackage

// File: rtl/calc_button_decoder.sv
// Keypad decoder: synchronizes and debounces raw button levels, rejects chords and
// emits one decoded press event per accepted press over a valid/ready handshake.
// Optional auto-repeat while a single key is held: define CALC_BTN_AUTOREPEAT_EN.
module calc_button_decoder #(
    parameter int unsigned DebounceCycles     = 1000,
    parameter int unsigned RepeatDelayCycles  = 50000,
    parameter int unsigned RepeatPeriodCycles = 10000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  calc_pkg::buttons_t       buttons_i,
    output calc_pkg::active_button_t button_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     overflow_o
);

    localparam int unsigned NumBtn  = $bits(calc_pkg::buttons_t);
    localparam int unsigned ButtonW = $bits(calc_pkg::active_button_t);
    localparam int unsigned CntW    = $clog2(DebounceCycles);

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESSED,
        S_JAMMED
    } state_e;

    // Elaboration-time parameter sanity checks.
    if (DebounceCycles < 2) begin : g_bad_debounce
        $error("DebounceCycles must be at least 2");
    end
    if (RepeatDelayCycles == 0 || RepeatPeriodCycles == 0) begin : g_bad_repeat
        $error("Repeat cycle counts must be nonzero");
    end

    logic [NumBtn-1:0]        r_sync1, r_sync2;
    logic [NumBtn-1:0]        r_cand, r_stable, r_latched;
    logic [CntW-1:0]          r_cnt;
    state_e                   r_state, w_state_d;
    logic                     w_zero, w_single, w_multi;
    logic                     w_req_press, w_latch, w_req;
    calc_pkg::active_button_t w_dec;
    calc_pkg::active_button_t r_button;
    logic                     r_valid, r_overflow;

    // Two-flop synchronizer for the asynchronous key levels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons_i;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a pattern must repeat DebounceCycles samples before it becomes stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
        end else if (r_cnt != CntW'(DebounceCycles - 1)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_stable <= r_cand;
        end
    end

    assign w_zero   = (r_stable == '0);
    assign w_single = $onehot(r_stable);
    assign w_multi  = !w_zero && !w_single;

    // Decode the set bit of the stable vector; only meaningful when exactly one is set.
    always_comb begin
        w_dec = calc_pkg::B_NONE;
        for (int i = 0; i < NumBtn; i++) begin
            if (r_stable[i]) begin
                w_dec = calc_pkg::active_button_t'(ButtonW'(i + 1));
            end
        end
    end

    // Press FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RELEASED;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Press FSM next state: one event per clean single press, anything else jams.
    always_comb begin
        w_state_d   = r_state;
        w_req_press = 1'b0;
        w_latch     = 1'b0;
        unique case (r_state)
            S_RELEASED: begin
                if (w_single) begin
                    w_state_d   = S_PRESSED;
                    w_req_press = 1'b1;
                    w_latch     = 1'b1;
                end else if (w_multi) begin
                    w_state_d = S_JAMMED;
                end
            end
            S_PRESSED: begin
                if (w_zero) begin
                    w_state_d = S_RELEASED;
                end else if (r_stable != r_latched) begin
                    w_state_d = S_JAMMED;
                end
            end
            S_JAMMED: begin
                if (w_zero) begin
                    w_state_d = S_RELEASED;
                end
            end
            default: w_state_d = S_RELEASED;
        endcase
    end

    // Remember which key started the current press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_latched <= '0;
        end else if (w_latch) begin
            r_latched <= r_stable;
        end
    end

`ifdef CALC_BTN_AUTOREPEAT_EN
    localparam int unsigned RepMax =
        (RepeatDelayCycles > RepeatPeriodCycles) ? RepeatDelayCycles : RepeatPeriodCycles;
    localparam int unsigned RepW = $clog2(RepMax + 1);

    logic [RepW-1:0] r_rep_cnt;
    logic            r_rep_phase;
    logic            w_rep_req;
    logic            w_in_press;

    assign w_in_press = (r_state == S_PRESSED) && (w_state_d == S_PRESSED);

    // Repeat request: first after the delay, then every period while held.
    always_comb begin
        w_rep_req = 1'b0;
        if (w_in_press) begin
            w_rep_req = r_rep_phase ? (r_rep_cnt == RepW'(RepeatPeriodCycles - 1))
                                    : (r_rep_cnt == RepW'(RepeatDelayCycles - 1));
        end
    end

    // Repeat counter runs only while the same key stays held.
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_in_press) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep_req) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign w_req = w_req_press | w_rep_req;
`else
    assign w_req = w_req_press;
`endif

    // Output event register; a request finding the slot still occupied is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_button   <= calc_pkg::B_NONE;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_req) begin
            if (!r_valid || ready_i) begin
                r_button <= w_dec;
                r_valid  <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign button_o   = r_button;
    assign valid_o    = r_valid;
    assign overflow_o = r_overflow;

endmodule

// File: doc/calc_button_decoder.md
Name: calc_button_decoder

Overview:
Converts the raw keypad `calc_pkg::buttons_t` field vector into debounced, single-button `calc_pkg::active_button_t` press events. This is the inverse of the one-hot button-expansion path. It sits between the keypad pins and the calculator control FSM, and delivers one event per accepted press over a valid/ready handshake. Multi-button chords are rejected, and presses that arrive while an event is still pending are dropped and flagged.

Parameters:
DebounceCycles, 1000, consecutive identical synchronized samples required before a new button state is accepted (>=2)
RepeatDelayCycles, 50000, cycles a single button must be held before the first auto-repeat (used only with CALC_BTN_AUTOREPEAT_EN)
RepeatPeriodCycles, 10000, cycles between subsequent auto-repeats (used only with CALC_BTN_AUTOREPEAT_EN)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; one clock, synchronous, active-high
buttons_i  input  $bits(calc_pkg::buttons_t)  raw asynchronous button levels, 1 = pressed
button_o  output  $bits(calc_pkg::active_button_t)  decoded button of the pending event
valid_o  output  1  event pending
ready_i  input  1  consumer accepts the event when valid_o & ready_i
overflow_o  output  1  sticky: an event was dropped

Behaviour:
- Reset: all internal registers cleared. valid_o=0, button_o='0, overflow_o=0, FSM in S_RELEASED.
- Synchronizer: sync1 <= buttons_i, then sync2 <= sync1.
- Debouncer (cand, cnt, stable):
  - If sync2 != cand: cand <= sync2 and cnt <= 0.
  - Else if cnt != DebounceCycles-1: cnt++.
  - Else: stable <= cand.
  - Any pattern that does not hold for DebounceCycles consecutive samples never reaches stable.
- Classification of stable: zero (no bits set), single (exactly one bit set), multi (two or more bits set).
- Decode: the single bit maps to its enum (num_5 -> B_NUM_5, op_eq -> B_OP_EQ, etc.). Decoding is combinational from stable.
- Press FSM, evaluated on stable each cycle:
  - S_RELEASED:
    - single -> raise event request, go to S_PRESSED, latch the pressed field.
    - multi -> go to S_JAMMED, no event.
    - zero -> stay.
  - S_PRESSED:
    - zero -> S_RELEASED.
    - stable differs from the latched field and is nonzero -> S_JAMMED, no event.
    - same -> stay.
  - S_JAMMED: stay until zero, then S_RELEASED. No events are raised from S_JAMMED.
  - Direct single-to-different-single transitions also go to S_JAMMED.
- Output register, updated on the edge after the event request:
  - Request with valid_o=0, or with valid_o&ready_i in the same cycle: button_o <= decoded value, valid_o <= 1.
  - Request with valid_o=1 and ready_i=0: request dropped, overflow_o <= 1, button_o unchanged.
  - No request and valid_o&ready_i: valid_o <= 0; button_o holds its last value.
  - overflow_o clears only on reset.
- Latency: with buttons_i stable from the first sampling edge E, valid_o rises at edge E+DebounceCycles+3.
- Release generates no event.
- Reset mid-press: stable returns to 0. A still-held button is re-debounced and produces a fresh event DebounceCycles+3 edges after rst_i deasserts.
- No combinational path from any input to any output.

Optional Feature:
CALC_BTN_AUTOREPEAT_EN
- Defined:
  - In S_PRESSED, a repeat counter starts at 0 on entry.
  - At RepeatDelayCycles, and every RepeatPeriodCycles thereafter, it raises another event request for the same button.
  - These requests follow the same overflow rules.
  - The counter clears on leaving S_PRESSED.
- Undefined: no repeat logic is present; one event per press; the Repeat* parameters are ignored.

Test Plan:
DebounceCycles=4 throughout; bench ready_i=1 unless stated.
1. Reset, buttons_i=0 for 20 cycles -> valid_o=0, button_o=0, overflow_o=0 throughout.
2. num_5 asserted at edge 10 and held 30 cycles, then released -> valid_o high only at edge 17, button_o=B_NUM_5, exactly one event; release yields nothing.
3. num_3 toggled every 2 cycles for 12 cycles, then held -> no event during bouncing; exactly one B_NUM_3 event 7 edges after the final steady edge.
4. op_add held, then op_mul added after 10 cycles; release both; press num_1 -> events B_OP_ADD then B_NUM_1 only; op_mul never reported. op_add+op_mul pressed simultaneously from idle -> no event.
5. ready_i=0: press/release num_1, then press num_2 -> valid_o stays 1 with button_o=B_NUM_1, overflow_o=1. Set ready_i=1 -> handshake completes, valid_o=0, overflow_o stays 1.
6. rst_i pulsed for 1 cycle while num_9 is held with an event pending -> valid_o=0, overflow_o=0 on the next edge; a fresh B_NUM_9 event appears 7 edges after rst_i deasserts.
